// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl
//  Description : Central stall/flush scheduler for the 5-stage pipeline.
//                Merges the data hazard, the EX branch-taken and the MEM SRAM
//                handshake into per-stage freeze/flush controls, tracks the
//                SRAM wait state with a sticky timeout, and keeps saturating
//                stall/flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             cnt_clr,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             freeze_back,
    output logic             mem_busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] hazard_cycles,
    output logic [CNT_W-1:0] mem_wait_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(MEM_TIMEOUT);

    state_t            r_state;
    state_t            w_stateNext;
    logic [TO_W-1:0]   r_waitCnt;
    logic [TO_W-1:0]   w_waitNext;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_hazardCycles;
    logic [CNT_W-1:0]  r_memWaitCycles;
    logic [CNT_W-1:0]  r_flushCount;
    logic              w_memStall;
    logic              w_hazardSel;
    logic              w_flushSel;

    // The SRAM not finishing this cycle is what actually holds the pipeline.
    assign w_memStall = mem_req & ~sram_ready;

    // Wait counter sticks at all-ones so a very long wait never looks short.
    assign w_waitNext = (r_waitCnt == {TO_W{1'b1}}) ? r_waitCnt : r_waitCnt + 1'b1;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Next-state and prioritised stage controls (memory > branch > hazard).
    always_comb begin
        w_stateNext  = r_state;
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        freeze_back  = 1'b0;
        w_hazardSel  = 1'b0;
        w_flushSel   = 1'b0;

        case (r_state)
            RUN:      if (w_memStall) w_stateNext = MEM_WAIT;
            MEM_WAIT: if (sram_ready || !mem_req) w_stateNext = RUN;
            default:  w_stateNext = RUN;
        endcase

        if (!rst) begin
            if (w_memStall) begin
                // Whole pipeline holds; branch/hazard stay asserted by the
                // frozen stages and get serviced after release.
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                freeze_back  = 1'b1;
            end else if (branch_taken) begin
                // ID instruction is squashed, so any hazard on it is moot.
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
                w_flushSel   = 1'b1;
            end else if (hazard) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                bubble_id_ex = 1'b1;
                w_hazardSel  = 1'b1;
            end
        end
    end

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == RUN && w_memStall) begin
                r_waitCnt <= '0;
            end else if (r_state == MEM_WAIT) begin
                r_waitCnt <= w_waitNext;
            end
            // Flag once the counter reaches the limit while still waiting;
            // the FSM itself keeps waiting.
            if (r_state == MEM_WAIT && w_memStall && w_waitNext >= c_TIMEOUT) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_hazardCycles  <= '0;
            r_memWaitCycles <= '0;
            r_flushCount    <= '0;
        end else begin
            if (w_hazardSel) r_hazardCycles  <= satInc(r_hazardCycles);
            if (w_memStall)  r_memWaitCycles <= satInc(r_memWaitCycles);
            if (w_flushSel)  r_flushCount    <= satInc(r_flushCount);
        end
    end

    assign mem_busy        = (r_state == MEM_WAIT);
    assign mem_timeout     = r_timeout;
    assign hazard_cycles   = r_hazardCycles;
    assign mem_wait_cycles = r_memWaitCycles;
    assign flush_count     = r_flushCount;

endmodule
`default_nettype wire

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage ARM pipeline.
- Combines three inputs into one consistent set of per-stage freeze/flush controls:
  - the data-hazard flag from the hazard unit;
  - branch-taken from EX;
  - the multi-cycle SRAM handshake from MEM.
- Tracks SRAM wait state, detects memory timeouts and keeps saturating performance counters for stall/flush events.

Parameters:
- MEM_TIMEOUT, 16: number of consecutive MEM_WAIT cycles after which mem_timeout is set (1..2^TO_W-1).
- TO_W, 8: width of the wait-cycle counter.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- hazard  in  1  RAW hazard from hazard unit (ID vs EX/MEM destinations)
- branch_taken  in  1  branch resolved taken in EX this cycle
- mem_req  in  1  MEM-stage instruction is a load or store
- sram_ready  in  1  SRAM controller completes the current access this cycle
- cnt_clr  in  1  synchronous clear of performance counters
- freeze_pc  out  1  hold PC register
- freeze_if_id  out  1  hold IF/ID register
- flush_if_id  out  1  load NOP into IF/ID
- bubble_id_ex  out  1  load NOP (all enables 0) into ID/EX
- freeze_back  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- mem_busy  out  1  state is MEM_WAIT
- mem_timeout  out  1  sticky: a wait exceeded MEM_TIMEOUT
- hazard_cycles  out  CNT_W  cycles a hazard bubble was inserted
- mem_wait_cycles  out  CNT_W  cycles the pipeline was frozen for SRAM
- flush_count  out  CNT_W  number of branch flushes

Behaviour:
- mem_stall = mem_req & ~sram_ready (combinational).
- Control outputs are combinational from inputs and state, with zero-cycle latency. Priority is mem_stall > branch_taken > hazard.
- mem_stall=1:
  - freeze_pc, freeze_if_id and freeze_back are 1.
  - flush_if_id=0, bubble_id_ex=0.
  - branch_taken and hazard are ignored; they remain asserted by the frozen stages and are serviced after release.
- Else branch_taken=1: flush_if_id=1, bubble_id_ex=1, all freezes 0. hazard is ignored because the ID instruction is being squashed.
- Else hazard=1: freeze_pc=1, freeze_if_id=1, bubble_id_ex=1, freeze_back=0, flush_if_id=0.
- Else: all control outputs are 0.
- FSM states:
  - RUN: to MEM_WAIT when mem_stall.
  - MEM_WAIT: to RUN when sram_ready=1 or mem_req=0; otherwise stay.
  - mem_busy = (state==MEM_WAIT).
- Same-cycle completion (mem_req=1, sram_ready=1 in RUN): no stall and no state change.
- The sram_ready cycle in MEM_WAIT is not stalled; the pipeline advances that edge.
- Wait counter:
  - cleared on entering MEM_WAIT;
  - increments each cycle spent in MEM_WAIT and saturates at all-ones;
  - when it reaches MEM_TIMEOUT while still waiting, mem_timeout is set the following cycle.
  - mem_timeout is sticky and cleared only by rst. The FSM keeps waiting after a timeout and does not abort.
- Performance counters:
  - hazard_cycles increments each cycle the hazard branch of the priority is taken.
  - mem_wait_cycles increments each cycle mem_stall=1.
  - flush_count increments each cycle the branch branch of the priority is taken.
  - All counters saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr has priority over increment in the same cycle; counters read 0 the next cycle.
- Reset:
  - state RUN, wait counter 0, mem_timeout 0, all counters 0.
  - During rst=1, all combinational control outputs are forced to 0.
  - Reset mid-MEM_WAIT returns to RUN immediately and does not set a timeout.

Test Plan:
- hazard=1 for 2 cycles, other inputs 0: freeze_pc=freeze_if_id=bubble_id_ex=1 both cycles, freeze_back=0; hazard_cycles=2.
- branch_taken=1 and hazard=1 together: flush_if_id=1, bubble_id_ex=1, freeze_pc=0; flush_count=1, hazard_cycles unchanged.
- mem_req=1, sram_ready low for 3 cycles then high:
  - freeze_pc/if_id/back=1 for 3 cycles; mem_busy=1 from cycle 2 to cycle 4;
  - RUN on the cycle after sram_ready; mem_wait_cycles=3.
- mem_req=1, sram_ready=0 with branch_taken=1 and hazard=1: only the freezes assert, flush_if_id=bubble_id_ex=0, flush_count unchanged.
- MEM_TIMEOUT=4, sram_ready held low 6 cycles: mem_timeout rises after the 4th wait cycle, stays 1 after release; rst clears it. Repeat with rst asserted in wait cycle 2: state RUN, mem_timeout=0.
- CNT_W=4, hazard held 20 cycles: hazard_cycles saturates at 15. Then cnt_clr with hazard=1: the next cycle reads 0, and it increments from then on.
